// File: rtl/puf_race_sequencer.sv
// RO-PUF response sequencer: per response bit, stages the scrambler/counter/arbiter resets,
// waits for the race result and collects it. Optional build macro: MAJORITY_VOTE_EN (3 races per bit).
module puf_race_sequencer #(
    parameter int RESP_BITS  = 8,
    parameter int CHAL_W     = 8,
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [CHAL_W-1:0]            challenge,
    output logic                         busy,
    output logic [CHAL_W-1:0]            chal_word,
    output logic [$clog2(RESP_BITS)-1:0] bit_idx,
    output logic                         scrambler_rst,
    output logic                         counter_rst,
    output logic                         arbiter_rst,
    input  logic                         race_done,
    input  logic                         race_winner,
    output logic [RESP_BITS-1:0]         response,
    output logic                         resp_valid,
    input  logic                         resp_ack,
    output logic                         timeout_err,
    output logic [2:0]                   dbg_state
);

    localparam int IDX_W = $clog2(RESP_BITS);
    localparam int HC_W  = $clog2(RST_CYCLES + 1);
    localparam int WC_W  = $clog2(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(RESP_BITS - 1);
    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(RST_CYCLES - 1);
    localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HOLD, S_REL_SCR, S_REL_CNT, S_RACE, S_NEXT, S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [HC_W-1:0]       r_hold_cnt;
    logic [WC_W-1:0]       r_wait_cnt;
    logic [IDX_W-1:0]      r_bit_idx;
    logic [CHAL_W-1:0]     r_chal;
    logic [RESP_BITS-1:0]  r_resp;
    logic                  r_valid;
    logic                  r_terr;
    logic                  w_wait_last;
    logic                  w_bit_done;

`ifdef MAJORITY_VOTE_EN
    logic [1:0]            r_vote_cnt;
    logic [1:0]            r_ones_cnt;
    assign w_bit_done = (r_vote_cnt == 2'd2);
`else
    assign w_bit_done = 1'b1;
`endif

    assign w_wait_last = (r_wait_cnt == WAIT_LAST);

    assign busy        = (r_state != S_IDLE);
    assign chal_word   = r_chal;
    assign bit_idx     = r_bit_idx;
    assign response    = r_resp;
    assign resp_valid  = r_valid;
    assign timeout_err = r_terr;
    assign dbg_state   = r_state;

    // Resets are asserted together and released one per cycle: scrambler, counter, arbiter.
    always_comb begin
        w_state_nxt   = r_state;
        scrambler_rst = 1'b1;
        counter_rst   = 1'b1;
        arbiter_rst   = 1'b1;
        case (r_state)
            S_IDLE:    if (start) w_state_nxt = S_HOLD;
            S_HOLD:    if (r_hold_cnt == HOLD_LAST) w_state_nxt = S_REL_SCR;
            S_REL_SCR: begin
                scrambler_rst = 1'b0;
                w_state_nxt   = S_REL_CNT;
            end
            S_REL_CNT: begin
                scrambler_rst = 1'b0;
                counter_rst   = 1'b0;
                w_state_nxt   = S_RACE;
            end
            S_RACE: begin
                scrambler_rst = 1'b0;
                counter_rst   = 1'b0;
                arbiter_rst   = 1'b0;
                if (race_done || w_wait_last) w_state_nxt = S_NEXT;
            end
            S_NEXT: begin
                if (w_bit_done && (r_bit_idx == LAST_IDX)) w_state_nxt = S_DONE;
                else                                         w_state_nxt = S_HOLD;
            end
            S_DONE:    if (resp_ack) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= '0;
            r_wait_cnt <= '0;
            r_bit_idx  <= '0;
            r_chal     <= '0;
            r_resp     <= '0;
            r_valid    <= 1'b0;
            r_terr     <= 1'b0;
`ifdef MAJORITY_VOTE_EN
            r_vote_cnt <= '0;
            r_ones_cnt <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= (r_state == S_HOLD) ? r_hold_cnt + 1'b1 : '0;
            r_wait_cnt <= (r_state == S_RACE) ? r_wait_cnt + 1'b1 : '0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_chal    <= challenge;
                        r_bit_idx <= '0;
                        r_terr    <= 1'b0;
                        r_resp    <= '0;
`ifdef MAJORITY_VOTE_EN
                        r_vote_cnt <= '0;
                        r_ones_cnt <= '0;
`endif
                    end
                end
                S_RACE: begin
                    // A done in the same cycle as the timeout wins.
                    if (race_done) begin
`ifdef MAJORITY_VOTE_EN
                        r_ones_cnt <= r_ones_cnt + {1'b0, race_winner};
`else
                        r_resp[r_bit_idx] <= race_winner;
`endif
                    end else if (w_wait_last) begin
                        r_terr <= 1'b1;
`ifndef MAJORITY_VOTE_EN
                        r_resp[r_bit_idx] <= 1'b0;
`endif
                    end
                end
                S_NEXT: begin
`ifdef MAJORITY_VOTE_EN
                    if (w_bit_done) begin
                        r_resp[r_bit_idx] <= (r_ones_cnt >= 2'd2);
                        r_vote_cnt        <= '0;
                        r_ones_cnt        <= '0;
                    end else begin
                        r_vote_cnt <= r_vote_cnt + 1'b1;
                    end
`endif
                    if (w_bit_done) begin
                        if (r_bit_idx == LAST_IDX) r_valid   <= 1'b1;
                        else                       r_bit_idx <= r_bit_idx + 1'b1;
                    end
                end
                S_DONE:  if (resp_ack) r_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
